// File: rtl/instruction_id_tracker.sv
// In-order instruction ID allocator and multi-port retirer.
// IDs are handed out at fetch, issued in order, marked complete by writeback
// ports, and retired oldest-first in contiguous blocks of up to RETIRE_PORTS.
module instruction_id_tracker #(
    parameter  int NUM_IDS       = 8,
    parameter  int RETIRE_PORTS  = 2,
    parameter  int NUM_WB_PORTS  = 2,
    parameter  int MAX_RD_RETIRE = 1,
    localparam int ID_W          = $clog2(NUM_IDS),
    localparam int CNT_W         = ID_W + 1,
    localparam int RC_W          = $clog2(RETIRE_PORTS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_flush,
    input  logic                           retire_hold,
    input  logic                           exception_pending,
    input  logic                           alloc_req,
    output logic [ID_W-1:0]                alloc_id,
    output logic                           alloc_available,
    input  logic                           issue_valid,
    output logic [ID_W-1:0]                issue_id,
    input  logic                           issue_needs_wb,
    input  logic                           issue_uses_rd,
    input  logic [NUM_WB_PORTS-1:0]        wb_valid,
    input  logic [NUM_WB_PORTS*ID_W-1:0]   wb_id,
    output logic [RETIRE_PORTS-1:0]        retire_valid,
    output logic [RETIRE_PORTS*ID_W-1:0]   retire_ids,
    output logic [RC_W-1:0]                retire_count,
    output logic [CNT_W-1:0]               pre_issue_count,
    output logic [CNT_W-1:0]               post_issue_count
);

    logic [ID_W-1:0]   alloc_ptr;
    logic [ID_W-1:0]   issue_ptr;
    logic [ID_W-1:0]   retire_ptr;
    logic [CNT_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  post_cnt;
    logic [NUM_IDS-1:0] pending;
    logic [NUM_IDS-1:0] uses_rd;
    logic [CNT_W-1:0]  occupancy;

    logic [RETIRE_PORTS-1:0]      sel;
    logic [RETIRE_PORTS*ID_W-1:0] sel_ids;
    logic [RC_W-1:0]              sel_count;
    logic [ID_W-1:0]              sel_idx;
    logic [RC_W-1:0]              rd_sum;
    logic                         sel_ok;
    logic                         sel_chain;

    assign alloc_id         = alloc_ptr;
    assign issue_id         = issue_ptr;
    assign pre_issue_count  = pre_cnt;
    assign post_issue_count = post_cnt;
    assign occupancy        = pre_cnt + post_cnt;
    assign alloc_available  = occupancy < CNT_W'(NUM_IDS);

    // Pick the longest contiguous run of retirable IDs starting at the oldest.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        sel       = '0;
        sel_ids   = '0;
        sel_count = '0;
        sel_idx   = '0;
        rd_sum    = '0;
        sel_ok    = 1'b0;
        sel_chain = 1'b1;
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            sel_idx = retire_ptr + ID_W'(i);
            sel_ids[i*ID_W +: ID_W] = sel_idx;
            if (uses_rd[sel_idx]) begin
                rd_sum = rd_sum + RC_W'(1);
            end
            sel_ok = sel_chain
                  && (post_cnt > CNT_W'(i))
                  && !pending[sel_idx]
                  && !retire_hold
                  && (rd_sum <= RC_W'(MAX_RD_RETIRE))
                  && ((i == 0) || !exception_pending);
            sel[i] = sel_ok;
            if (sel_ok) begin
                sel_count = sel_count + RC_W'(1);
            end
            sel_chain = sel_ok;
        end
    end

    // Pointer, count, per-ID status and registered retire outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr    <= '0;
            issue_ptr    <= '0;
            retire_ptr   <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            // NOTE: the per-ID status bits are plain flops, so they are reset along with everything else.
            pending      <= '0;
            uses_rd      <= '0;
            retire_valid <= '0;
            retire_count <= '0;
            for (int i = 0; i < RETIRE_PORTS; i++) begin
                retire_ids[i*ID_W +: ID_W] <= ID_W'(i);
            end
        end else begin
            // NOTE: non-blocking so every update below sees the pre-edge state.
            retire_ptr <= retire_ptr + ID_W'(sel_count);
            post_cnt   <= post_cnt + CNT_W'(issue_valid) - CNT_W'(sel_count);

            if (issue_valid) begin
                issue_ptr <= issue_ptr + ID_W'(1);
            end

            if (fetch_flush) begin
                alloc_ptr <= issue_ptr + ID_W'(issue_valid);
                pre_cnt   <= '0;
            end else begin
                if (alloc_req) begin
                    alloc_ptr <= alloc_ptr + ID_W'(1);
                end
                pre_cnt <= pre_cnt + CNT_W'(alloc_req) - CNT_W'(issue_valid);
            end

            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                if (wb_valid[k]) begin
                    pending[wb_id[k*ID_W +: ID_W]] <= 1'b0;
                end
            end

            if (issue_valid) begin
                pending[issue_ptr] <= issue_needs_wb;
                uses_rd[issue_ptr] <= issue_uses_rd;
            end

            retire_valid <= sel;
            retire_ids   <= sel_ids;
            retire_count <= sel_count;
        end
    end

    // Usage rules the surrounding pipeline must honour.
    a_alloc_legal : assert property (@(posedge clk) disable iff (rst)
        alloc_req |-> alloc_available);
    a_issue_legal : assert property (@(posedge clk) disable iff (rst)
        issue_valid |-> (pre_cnt != '0));

    for (genvar k = 0; k < NUM_WB_PORTS; k++) begin : g_wb_chk
        a_wb_pending : assert property (@(posedge clk) disable iff (rst)
            wb_valid[k] |-> pending[wb_id[k*ID_W +: ID_W]]);
        a_wb_not_issuing : assert property (@(posedge clk) disable iff (rst)
            (wb_valid[k] && issue_valid) |-> (wb_id[k*ID_W +: ID_W] != issue_ptr));
        for (genvar j = k + 1; j < NUM_WB_PORTS; j++) begin : g_pair
            a_wb_distinct : assert property (@(posedge clk) disable iff (rst)
                (wb_valid[k] && wb_valid[j]) |-> (wb_id[k*ID_W +: ID_W] != wb_id[j*ID_W +: ID_W]));
        end
    end

endmodule
